// File: rtl/cvm300_spi_responder.sv
// CVM300 sensor-side SPI responder: 128x8 register file behind an RW+address+data serial frame.
// Optional frame-error tracking is enabled with `define CVM300_SPI_FRAME_CHECK_EN.
module cvm300_spi_responder #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              CVM300_SPI_CLK,
  input  logic              CVM300_SPI_EN,
  input  logic              CVM300_SPI_IN,
  output logic              CVM300_SPI_OUT,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic [2:0]        fsm_state
);

  localparam int DEPTH      = 1 << ADDR_W;
  localparam int CMD_BITS   = ADDR_W + 1;
  localparam int FRAME_BITS = CMD_BITS + DATA_W;
  localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_DATA   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t state, state_n;

  logic clk_s1, clk_s2, clk_s3;
  logic en_s1, en_s2;
  logic in_s1, in_s2;
  logic clk_rise, clk_fall;
  logic abort;

  logic [4:0]        bit_cnt;
  logic [ADDR_W:0]   cmd_sr;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] tx_sr;
  logic              spi_out;
  logic              frame_rw;
  logic [ADDR_W-1:0] frame_addr;

  logic [DATA_W-1:0] regfile [DEPTH];

  // CLK, EN and IN share the same synchronizer depth so a detected rise lines up with IN.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      clk_s1 <= 1'b0;
      clk_s2 <= 1'b0;
      clk_s3 <= 1'b0;
      en_s1  <= 1'b0;
      en_s2  <= 1'b0;
      in_s1  <= 1'b0;
      in_s2  <= 1'b0;
    end else begin
      clk_s1 <= CVM300_SPI_CLK;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      en_s1  <= CVM300_SPI_EN;
      en_s2  <= en_s1;
      in_s1  <= CVM300_SPI_IN;
      in_s2  <= in_s1;
    end
  end

  assign clk_rise   = clk_s2 & ~clk_s3;
  assign clk_fall   = ~clk_s2 & clk_s3;
  assign frame_rw   = cmd_sr[ADDR_W];
  assign frame_addr = cmd_sr[ADDR_W-1:0];
  assign fsm_state  = state;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    abort   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en_s2) state_n = ST_CMD;
      end
      ST_CMD: begin
        if (!en_s2) begin
          state_n = ST_IDLE;
          abort   = 1'b1;
        end else if (clk_rise && bit_cnt == CMD_LAST) begin
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!en_s2) begin
          state_n = ST_IDLE;
          abort   = 1'b1;
        end else if (clk_rise && bit_cnt == FRAME_LAST) begin
          state_n = frame_rw ? ST_COMMIT : ST_HOLD;
        end
      end
      ST_COMMIT: state_n = ST_HOLD;
      ST_HOLD: begin
        if (!en_s2) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      data_sr   <= '0;
      tx_sr     <= '0;
      spi_out   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          spi_out <= 1'b0;
        end
        ST_CMD: begin
          if (!en_s2) begin
            spi_out <= 1'b0;
          end else if (clk_rise) begin
            cmd_sr  <= {cmd_sr[ADDR_W-1:0], in_s2};
            bit_cnt <= bit_cnt + 5'd1;
            // On the last command bit RW already sits one below the top of cmd_sr.
            if (bit_cnt == CMD_LAST && !cmd_sr[ADDR_W-1])
              tx_sr <= regfile[{cmd_sr[ADDR_W-2:0], in_s2}];
          end
        end
        ST_DATA: begin
          if (!en_s2) begin
            spi_out <= 1'b0;
          end else begin
            if (clk_rise) begin
              data_sr <= {data_sr[DATA_W-2:0], in_s2};
              bit_cnt <= bit_cnt + 5'd1;
            end
            // Drive on the falling edge so the bit is settled before the master's next rise.
            if (clk_fall && !frame_rw) begin
              spi_out <= tx_sr[DATA_W-1];
              tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end
        end
        ST_COMMIT: begin
          spi_out <= 1'b0;
        end
        ST_HOLD: begin
          if (clk_fall || !en_s2) spi_out <= 1'b0;
        end
        default: spi_out <= 1'b0;
      endcase

      wr_strobe <= (state == ST_COMMIT);
      if (state == ST_COMMIT) begin
        wr_addr <= frame_addr;
        wr_data <= data_sr;
      end
    end
  end

  assign CVM300_SPI_OUT = spi_out;

  // Host read is sampled before the commit lands, giving read-before-write on collisions.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
      host_rdata <= '0;
    end else begin
      host_rdata <= regfile[host_addr];
      if (state == ST_COMMIT) regfile[frame_addr] <= data_sr;
    end
  end

`ifdef CVM300_SPI_FRAME_CHECK_EN
  logic en_s3;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      en_s3     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      en_s3 <= en_s2;
      // Any rise in HOLD is beyond the last frame bit.
      if (abort ||
          (state == ST_HOLD && clk_rise) ||
          ((state == ST_HOLD || state == ST_COMMIT) && en_s2 && !en_s3))
        frame_err <= 1'b1;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_cvm300_spi_responder.sv
// Bench for cvm300_spi_responder: directed vector table, reset-mid-frame sequence, random frames.
module tb_cvm300_spi_responder;

  localparam int HALF = 6;
  localparam int GAP  = 2 * HALF;

  logic       sys_clk = 1'b0;
  logic       reset_n;
  logic       spi_clk, spi_en, spi_in, spi_out;
  logic [6:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [2:0] fsm_state;

  int total = 0;
  int bad   = 0;
  int strobe_cycles = 0;

  logic [7:0] mdl [128];
  logic [6:0] last_wa;
  logic [7:0] last_wd;
  logic       exp_err;

  always #5 sys_clk = ~sys_clk;

  cvm300_spi_responder dut (
    .sys_clk        (sys_clk),
    .reset_n        (reset_n),
    .CVM300_SPI_CLK (spi_clk),
    .CVM300_SPI_EN  (spi_en),
    .CVM300_SPI_IN  (spi_in),
    .CVM300_SPI_OUT (spi_out),
    .host_addr      (host_addr),
    .host_rdata     (host_rdata),
    .wr_strobe      (wr_strobe),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .frame_err      (frame_err),
    .fsm_state      (fsm_state)
  );

  always @(negedge sys_clk) if (wr_strobe === 1'b1) strobe_cycles++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
    last_wa = 7'h00;
    last_wd = 8'h00;
    exp_err = 1'b0;
  endtask

  // Drives one frame as the master; rd collects OUT sampled just before rises 9..16.
  task automatic spi_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                           input int abort_at, input int rst_at, input int gap,
                           output logic [7:0] rd);
    logic [15:0] bits;
    bits = {rw, a, d};
    rd = 8'h00;
    spi_en = 1'b1;
    wait_cyc(HALF);
    for (int b = 0; b < 16; b++) begin
      spi_in = bits[15-b];
      wait_cyc(HALF);
      if (b >= 8) rd = {rd[6:0], spi_out};
      spi_clk = 1'b1;
      wait_cyc(HALF);
      spi_clk = 1'b0;
      if (rst_at == b + 1) begin
        reset_n = 1'b0;
        wait_cyc(2);
        spi_en = 1'b0;
        spi_in = 1'b0;
        wait_cyc(3);
        reset_n = 1'b1;
        break;
      end
      if (abort_at == b + 1) break;
    end
    wait_cyc(HALF);
    spi_en = 1'b0;
    spi_in = 1'b0;
    wait_cyc(gap);
  endtask

  task automatic host_read(input string name, input logic [6:0] a, input logic [7:0] exp);
    host_addr = a;
    wait_cyc(1);
    check(name, host_rdata, exp);
  endtask

  task automatic run_frame(input string tag, input logic rw, input logic [6:0] a,
                           input logic [7:0] d, input int abort_at, input int gap,
                           input int exp_strobe, input logic chk_rd, input logic [7:0] exp_rd,
                           input logic [7:0] exp_host);
    int s0;
    logic [7:0] rd;
    s0 = strobe_cycles;
    spi_frame(rw, a, d, abort_at, 0, gap, rd);
    if (abort_at == 0 && rw) begin
      mdl[a]  = d;
      last_wa = a;
      last_wd = d;
    end
`ifdef CVM300_SPI_FRAME_CHECK_EN
    if (abort_at != 0) exp_err = 1'b1;
`endif
    check({tag, "_strobe"}, strobe_cycles - s0, exp_strobe);
    if (chk_rd) check({tag, "_out"}, rd, exp_rd);
    check({tag, "_wr_addr"}, wr_addr, last_wa);
    check({tag, "_wr_data"}, wr_data, last_wd);
    check({tag, "_frame_err"}, frame_err, exp_err);
    check({tag, "_state"}, fsm_state, 3'd0);
    host_read({tag, "_host"}, a, exp_host);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] a;
    logic [7:0] d;
    int         abort_at;
    int         gap;
    int         exp_strobe;
    logic [7:0] exp_rd;
    logic [7:0] exp_host;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] rd;
    int s0;
    tbl[0] = '{1'b1, 7'h3A, 8'hC5, 0,  GAP, 1, 8'h00, 8'hC5};
    tbl[1] = '{1'b0, 7'h3A, 8'h00, 0,  GAP, 0, 8'hC5, 8'hC5};
    tbl[2] = '{1'b1, 7'h10, 8'hFF, 12, GAP, 0, 8'h00, 8'h00};
    tbl[3] = '{1'b1, 7'h7F, 8'h01, 0,  GAP, 1, 8'h00, 8'h01};
    tbl[4] = '{1'b0, 7'h7F, 8'h00, 0,  GAP, 0, 8'h01, 8'h01};
    tbl[5] = '{1'b1, 7'h00, 8'h5A, 0,  GAP, 1, 8'h00, 8'h5A};
    tbl[6] = '{1'b0, 7'h00, 8'h00, 0,  GAP, 0, 8'h5A, 8'h5A};
    tbl[7] = '{1'b0, 7'h7F, 8'h00, 0,  GAP, 0, 8'h01, 8'h01};

    reset_n   = 1'b0;
    spi_clk   = 1'b0;
    spi_en    = 1'b0;
    spi_in    = 1'b0;
    host_addr = 7'h05;
    model_reset();
    wait_cyc(4);
    reset_n = 1'b1;
    wait_cyc(1);
    check("rst_host_rdata", host_rdata, 8'h00);
    check("rst_out", spi_out, 1'b0);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 7'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_state", fsm_state, 3'd0);

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].abort_at,
                tbl[i].gap, tbl[i].exp_strobe, 1'b1, tbl[i].exp_rd, tbl[i].exp_host);

    // Reset lands mid-write; the frame must vanish along with all register contents.
    s0 = strobe_cycles;
    spi_frame(1'b1, 7'h20, 8'hAA, 0, 10, GAP, rd);
    model_reset();
    check("rstmid_strobe", strobe_cycles - s0, 0);
    check("rstmid_state", fsm_state, 3'd0);
    check("rstmid_frame_err", frame_err, 1'b0);
    check("rstmid_wr_addr", wr_addr, 7'h00);
    host_read("rstmid_host20", 7'h20, 8'h00);
    host_read("rstmid_host3a", 7'h3A, 8'h00);
    run_frame("post_rst_wr", 1'b1, 7'h20, 8'hAA, 0, GAP, 1, 1'b1, 8'h00, 8'hAA);

    for (int n = 0; n < 30; n++) begin
      logic       rw;
      logic [6:0] a;
      logic [7:0] d;
      int         ab;
      logic [7:0] eh;
      rw = 1'($urandom_range(0, 1));
      a  = (n % 3 == 0) ? tbl[n % 8].a : 7'($urandom_range(0, 127));
      d  = 8'($urandom_range(0, 255));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 0;
      eh = (rw && ab == 0) ? d : mdl[a];
      run_frame($sformatf("rnd%0d", n), rw, a, d, ab, GAP,
                (rw && ab == 0) ? 1 : 0, (ab == 0), rw ? 8'h00 : mdl[a], eh);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
